// File: rtl/seq_alu.sv
// seq_alu: registered ALU with valid/ready handshakes on request and response.
// Single-cycle ops register their result at the accepting edge. Multiply and
// divide iterate one bit per cycle: shift-add for mul, restoring for div.
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       selector,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             carry_in_flag,
  input  logic             borrow_in_flag,
  input  logic             rotate_shift,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             carry_out_flag,
  output logic             borrow_out_flag,
  output logic             overflow_flag,
  output logic             zero_flag,
  output logic             div_zero_flag,
  output logic             illegal_flag
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_SUB = 5'd1;
  localparam logic [4:0] OP_SHR = 5'd2;
  localparam logic [4:0] OP_SHL = 5'd3;
  localparam logic [4:0] OP_AND = 5'd4;
  localparam logic [4:0] OP_OR  = 5'd5;
  localparam logic [4:0] OP_NOT = 5'd6;
  localparam logic [4:0] OP_GT  = 5'd7;
  localparam logic [4:0] OP_LT  = 5'd8;
  localparam logic [4:0] OP_EQ  = 5'd9;
  localparam logic [4:0] OP_NE  = 5'd10;
  localparam logic [4:0] OP_MUL = 5'd11;
  localparam logic [4:0] OP_DIV = 5'd12;
  localparam logic [4:0] OP_XOR = 5'd13;

  logic [1:0]       state;
  logic             is_div;
  logic [WIDTH-1:0] acc;   // mul: running high half; div: partial remainder
  logic [WIDTH-1:0] wq;    // mul: multiplier / low half; div: dividend / quotient
  logic [WIDTH-1:0] dvsr;  // mul: multiplicand; div: divisor
  logic [SHW-1:0]   cnt;

  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   dif_ext;
  logic [SHW-1:0]   sh_d;
  logic [WIDTH-1:0] s_res, s_hi;
  logic             s_c, s_b, s_ov, s_dz, s_il;
  logic             start_multi;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_sh;
  logic             div_ge;
  logic [WIDTH-1:0] n_acc, n_q;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  assign sum_ext = {1'b0, operand_a} + {1'b0, operand_b} + {{WIDTH{1'b0}}, carry_in_flag};
  assign dif_ext = {1'b0, operand_a} - {1'b0, operand_b} - {{WIDTH{1'b0}}, borrow_in_flag};
  assign sh_d    = operand_b[SHW-1:0];
  assign start_multi = (selector == OP_MUL) ||
                       ((selector == OP_DIV) && (operand_b != '0));

  // Single-cycle result and flags, evaluated from the live request inputs.
  // A distance of 0 shifts the wrap term by WIDTH, which yields 0, so the
  // rotate expressions pass operand_a through unchanged.
  always_comb begin
    s_res = '0;
    s_hi  = '0;
    s_c   = 1'b0;
    s_b   = 1'b0;
    s_ov  = 1'b0;
    s_dz  = 1'b0;
    s_il  = 1'b0;
    case (selector)
      OP_ADD: begin
        s_res = sum_ext[WIDTH-1:0];
        s_c   = sum_ext[WIDTH];
        s_ov  = (operand_a[WIDTH-1] == operand_b[WIDTH-1]) &&
                (sum_ext[WIDTH-1] != operand_a[WIDTH-1]);
      end
      OP_SUB: begin
        s_res = dif_ext[WIDTH-1:0];
        s_b   = dif_ext[WIDTH];
        s_ov  = (operand_a[WIDTH-1] != operand_b[WIDTH-1]) &&
                (dif_ext[WIDTH-1] != operand_a[WIDTH-1]);
      end
      OP_SHR: begin
        s_res = operand_a >> sh_d;
        if (rotate_shift)
          s_res = s_res | (operand_a << (WIDTH - int'(sh_d)));
      end
      OP_SHL: begin
        s_res = operand_a << sh_d;
        if (rotate_shift)
          s_res = s_res | (operand_a >> (WIDTH - int'(sh_d)));
      end
      OP_AND: s_res = operand_a & operand_b;
      OP_OR:  s_res = operand_a | operand_b;
      OP_NOT: s_res = ~operand_a;
      OP_XOR: s_res = operand_a ^ operand_b;
      OP_GT:  s_res = {{(WIDTH-1){1'b0}}, operand_a >  operand_b};
      OP_LT:  s_res = {{(WIDTH-1){1'b0}}, operand_a <  operand_b};
      OP_EQ:  s_res = {{(WIDTH-1){1'b0}}, operand_a == operand_b};
      OP_NE:  s_res = {{(WIDTH-1){1'b0}}, operand_a != operand_b};
      OP_MUL: s_res = '0;
      OP_DIV: begin
        s_res = '1;
        s_hi  = operand_a;
        s_dz  = 1'b1;
      end
      default: s_il = 1'b1;
    endcase
  end

  // One multiply or divide iteration from the current working registers.
  always_comb begin
    mul_sum = {1'b0, acc} + (wq[0] ? {1'b0, dvsr} : '0);
    div_sh  = {acc, wq[WIDTH-1]};
    div_ge  = (div_sh >= {1'b0, dvsr});
    if (is_div) begin
      n_acc = div_ge ? (div_sh[WIDTH-1:0] - dvsr) : div_sh[WIDTH-1:0];
      n_q   = {wq[WIDTH-2:0], div_ge};
    end else begin
      n_acc = mul_sum[WIDTH:1];
      n_q   = {mul_sum[0], wq[WIDTH-1:1]};
    end
  end

  // Handshake FSM, working registers and registered outputs.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state           <= IDLE;
      is_div          <= 1'b0;
      acc             <= '0;
      wq              <= '0;
      dvsr            <= '0;
      cnt             <= '0;
      result          <= '0;
      result_hi       <= '0;
      carry_out_flag  <= 1'b0;
      borrow_out_flag <= 1'b0;
      overflow_flag   <= 1'b0;
      zero_flag       <= 1'b0;
      div_zero_flag   <= 1'b0;
      illegal_flag    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (start_multi) begin
              is_div <= (selector == OP_DIV);
              acc    <= '0;
              wq     <= operand_a;
              dvsr   <= operand_b;
              cnt    <= SHW'(WIDTH - 1);
              state  <= BUSY;
            end else begin
              result          <= s_res;
              result_hi       <= s_hi;
              carry_out_flag  <= s_c;
              borrow_out_flag <= s_b;
              overflow_flag   <= s_ov;
              zero_flag       <= (s_res == '0);
              div_zero_flag   <= s_dz;
              illegal_flag    <= s_il;
              state           <= DONE;
            end
          end
        end
        BUSY: begin
          acc <= n_acc;
          wq  <= n_q;
          cnt <= cnt - SHW'(1);
          if (cnt == '0) begin
            result          <= n_q;
            result_hi       <= n_acc;
            carry_out_flag  <= 1'b0;
            borrow_out_flag <= 1'b0;
            overflow_flag   <= 1'b0;
            zero_flag       <= (n_q == '0);
            div_zero_flag   <= 1'b0;
            illegal_flag    <= 1'b0;
            state           <= DONE;
          end
        end
        DONE: begin
          if (out_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed cases plus random operations,
// compared against a plain-arithmetic reference model.
module tb_seq_alu;

  localparam int W = 32;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [4:0]   selector = '0;
  logic [W-1:0] operand_a = '0;
  logic [W-1:0] operand_b = '0;
  logic         carry_in_flag = 1'b0;
  logic         borrow_in_flag = 1'b0;
  logic         rotate_shift = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic [W-1:0] result_hi;
  logic         carry_out_flag;
  logic         borrow_out_flag;
  logic         overflow_flag;
  logic         zero_flag;
  logic         div_zero_flag;
  logic         illegal_flag;

  int checks = 0;
  int errors = 0;

  seq_alu #(.WIDTH(W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .in_valid(in_valid), .in_ready(in_ready),
    .selector(selector), .operand_a(operand_a), .operand_b(operand_b),
    .carry_in_flag(carry_in_flag), .borrow_in_flag(borrow_in_flag),
    .rotate_shift(rotate_shift),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .result_hi(result_hi),
    .carry_out_flag(carry_out_flag), .borrow_out_flag(borrow_out_flag),
    .overflow_flag(overflow_flag), .zero_flag(zero_flag),
    .div_zero_flag(div_zero_flag), .illegal_flag(illegal_flag)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: flags packed as {carry, borrow, ovf, zero, div_zero, illegal}.
  function automatic void model(input logic [4:0] sel, input logic [31:0] a, b,
                                input logic cin, bin, rot,
                                output logic [31:0] r, output logic [31:0] hi,
                                output logic [5:0] flags, output int lat);
    longint unsigned aa, bb, t;
    int d;
    logic c, bo, ov, dz, il;
    aa = 64'(a); bb = 64'(b);
    d  = int'(b[4:0]);
    r = '0; hi = '0; c = 0; bo = 0; ov = 0; dz = 0; il = 0; lat = 1;
    case (sel)
      5'd0: begin
        t = aa + bb + 64'(cin);
        r = t[31:0]; c = t[32];
        ov = (a[31] == b[31]) && (r[31] != a[31]);
      end
      5'd1: begin
        t = aa - bb - 64'(bin);
        r = t[31:0];
        bo = (aa < bb + 64'(bin));
        ov = (a[31] != b[31]) && (r[31] != a[31]);
      end
      5'd2: begin
        t = rot ? ((aa >> d) | (aa << (32 - d))) : (aa >> d);
        r = t[31:0];
      end
      5'd3: begin
        t = rot ? ((aa << d) | (aa >> (32 - d))) : (aa << d);
        r = t[31:0];
      end
      5'd4:  r = a & b;
      5'd5:  r = a | b;
      5'd6:  r = ~a;
      5'd7:  r = (a >  b) ? 32'd1 : 32'd0;
      5'd8:  r = (a <  b) ? 32'd1 : 32'd0;
      5'd9:  r = (a == b) ? 32'd1 : 32'd0;
      5'd10: r = (a != b) ? 32'd1 : 32'd0;
      5'd11: begin
        t = aa * bb;
        r = t[31:0]; hi = t[63:32]; lat = 33;
      end
      5'd12: begin
        if (b == 0) begin
          r = 32'hFFFF_FFFF; hi = a; dz = 1;
        end else begin
          t = aa / bb; r = t[31:0];
          t = aa % bb; hi = t[31:0];
          lat = 33;
        end
      end
      5'd13: r = a ^ b;
      default: il = 1;
    endcase
    flags = {c, bo, ov, (r == 0), dz, il};
  endfunction

  // Presents a request, waits for acceptance, then scrambles the inputs while
  // keeping in_valid high until the response shows up.
  task automatic issue(input logic [4:0] sel, input logic [31:0] a, b,
                       input logic cin, bin, rot,
                       output int lat, output bit busy_ready);
    int n;
    @(negedge clk_i);
    selector = sel; operand_a = a; operand_b = b;
    carry_in_flag = cin; borrow_in_flag = bin; rotate_shift = rot;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    @(negedge clk_i);
    operand_a = $urandom; operand_b = $urandom; selector = 5'($urandom);
    carry_in_flag = 1'($urandom); borrow_in_flag = 1'($urandom);
    rotate_shift = 1'($urandom);
    lat = 1; busy_ready = 0;
    while (!out_valid && lat < 100) begin
      if (in_ready) busy_ready = 1;
      @(negedge clk_i);
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [4:0] sel, input logic [31:0] a, b,
                        input logic cin, bin, rot);
    logic [31:0] er, eh;
    logic [5:0]  ef;
    int          elat, lat;
    bit          br;
    model(sel, a, b, cin, bin, rot, er, eh, ef, elat);
    issue(sel, a, b, cin, bin, rot, lat, br);
    in_valid = 1'b0;
    chk({tag, ".lat"}, 64'(lat), 64'(elat));
    chk({tag, ".busy_ready"}, 64'(br), 64'(0));
    chk({tag, ".done_ready"}, 64'(in_ready), 64'(0));
    chk({tag, ".res"}, 64'(result), 64'(er));
    chk({tag, ".hi"}, 64'(result_hi), 64'(eh));
    chk({tag, ".flags"},
        64'({carry_out_flag, borrow_out_flag, overflow_flag, zero_flag,
             div_zero_flag, illegal_flag}), 64'(ef));
    out_ready = 1'b1;
    @(negedge clk_i);
    out_ready = 1'b0;
    chk({tag, ".idle_valid"}, 64'(out_valid), 64'(0));
    chk({tag, ".idle_ready"}, 64'(in_ready), 64'(1));
    chk({tag, ".idle_res"}, 64'(result), 64'(er));
  endtask

  initial begin
    int  lat;
    bit  br;
    bit  stale;
    logic [4:0]  rs;
    logic [31:0] ra, rb;

    // Reset state
    repeat (3) @(negedge clk_i);
    chk("rst.valid", 64'(out_valid), 64'(0));
    chk("rst.ready", 64'(in_ready), 64'(1));
    chk("rst.res", 64'(result), 64'(0));
    rst_i = 1'b1;

    // Add/sub flags
    run_op("add_wrap", 5'd0, 32'hFFFF_FFFF, 32'h1, 0, 0, 0);
    run_op("add_ovf",  5'd0, 32'h7FFF_FFFF, 32'h1, 0, 0, 0);
    run_op("add_cin",  5'd0, 32'h0000_0010, 32'h22, 1, 0, 0);
    run_op("sub_brw",  5'd1, 32'd5, 32'd7, 0, 0, 0);
    run_op("sub_bin",  5'd1, 32'd7, 32'd7, 0, 1, 0);
    run_op("sub_ovf",  5'd1, 32'h8000_0000, 32'h1, 0, 0, 0);

    // Shifts and rotates, including distance 0
    run_op("shl_log", 5'd3, 32'h8000_0001, 32'd1, 0, 0, 0);
    run_op("shl_rot", 5'd3, 32'h8000_0001, 32'd1, 0, 0, 1);
    run_op("shr_rot", 5'd2, 32'h0000_000F, 32'd4, 0, 0, 1);
    run_op("shr_log", 5'd2, 32'hF000_000F, 32'd4, 0, 0, 0);
    run_op("shl_d0",  5'd3, 32'hDEAD_BEEF, 32'h20, 0, 0, 1);
    run_op("shr_d0",  5'd2, 32'hDEAD_BEEF, 32'h0, 0, 0, 0);

    // Multiply / divide, including divide by zero
    run_op("mul_max", 5'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0);
    run_op("div_100_7", 5'd12, 32'd100, 32'd7, 0, 0, 0);
    run_op("div_zero",  5'd12, 32'd9, 32'd0, 0, 0, 0);
    run_op("div_small", 5'd12, 32'd3, 32'd10, 0, 0, 0);

    // Backpressure on an eq response; new requests are ignored while held
    issue(5'd9, 32'd5, 32'd5, 0, 0, 0, lat, br);
    chk("eq.lat", 64'(lat), 64'(1));
    chk("eq.res", 64'(result), 64'(1));
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; selector = 5'd0; operand_a = $urandom; operand_b = $urandom;
      @(negedge clk_i);
      chk("bp.valid", 64'(out_valid), 64'(1));
      chk("bp.ready", 64'(in_ready), 64'(0));
      chk("bp.res", 64'(result), 64'(1));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk_i);
    out_ready = 1'b0;
    chk("bp.release", 64'(out_valid), 64'(0));
    chk("bp.held", 64'(result), 64'(1));

    // Illegal opcode
    run_op("illegal20", 5'd20, 32'h1234_5678, 32'h9ABC_DEF0, 1, 1, 1);

    // Reset in the middle of a multiply: no response may surface afterwards
    @(negedge clk_i);
    selector = 5'd11; operand_a = 32'h1234_5678; operand_b = 32'h0000_1001;
    in_valid = 1'b1;
    @(negedge clk_i);
    in_valid = 1'b0;
    repeat (5) @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    chk("midrst.valid", 64'(out_valid), 64'(0));
    chk("midrst.ready", 64'(in_ready), 64'(1));
    chk("midrst.res", 64'(result), 64'(0));
    chk("midrst.hi", 64'(result_hi), 64'(0));
    chk("midrst.flags",
        64'({carry_out_flag, borrow_out_flag, overflow_flag, zero_flag,
             div_zero_flag, illegal_flag}), 64'(0));
    @(negedge clk_i);
    rst_i = 1'b1;
    stale = 0;
    repeat (40) begin
      @(negedge clk_i);
      if (out_valid) stale = 1;
    end
    chk("midrst.stale", 64'(stale), 64'(0));

    // Random operations
    for (int i = 0; i < 40; i++) begin
      rs = 5'($urandom_range(0, 15));
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : 32'($urandom);
      run_op("rand", rs, ra, rb, 1'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
